// File: rtl/ring_pkg.sv
// Shared types and constants for the ring shift-register datapath.
package ring_pkg;

  localparam int unsigned RING_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ring_state_e;

  // Counter must hold both the bit index and the gap count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned gap);
    int unsigned m;
    m = (width > gap + 1) ? width : gap + 1;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ring_word_tx_piso.sv
// Loadable shift register with serial-out tap; bit order set by RING_WORD_TX_LSB_FIRST_EN.
module piso_shifter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
`ifdef RING_WORD_TX_LSB_FIRST_EN
      sreg <= {1'b0, sreg[WIDTH-1:1]};
`else
      sreg <= {sreg[WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef RING_WORD_TX_LSB_FIRST_EN
  assign sout = sreg[0];
`else
  assign sout = sreg[WIDTH-1];
`endif

endmodule

// File: rtl/ring_word_tx.sv
// Word-to-serial transmitter feeding a ring register's (ld, data) load port.
// Optional LSB-first ordering via RING_WORD_TX_LSB_FIRST_EN.
module ring_word_tx
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = RING_WIDTH,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld,
  output logic             data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH, GAP);

  ring_state_e   state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_bit;
  logic          sout;

  // rst gates in_ready directly so no word is accepted while reset is held.
  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));
  assign ld       = (state == ST_SHIFT);
  assign data     = (state == ST_SHIFT) && sout;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_bit;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            cnt   <= '0;
            state <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  piso_shifter #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state == ST_SHIFT),
    .load_data(in_data),
    .sout     (sout)
  );

endmodule
